// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB multi-channel bridge.
package apb_pkg;

  localparam int APB_ADDR_WIDTH  = 32;
  localparam int APB_DATA_WIDTH  = 32;
  localparam int APB_PSTRB_WIDTH = APB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ERR
  } apb_bridge_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_DECODE,
    ERR_SECURE,
    ERR_STRB,
    ERR_TIMEOUT
  } apb_err_cause_e;

  // Channel index width, never zero so a single-channel build still has a legal vector.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_multi_slave_bridge_if.sv
// APB4 completer-side bus bundle; the master modport is the interconnect, slave is the bridge.
interface apb_multi_slave_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int PSTRB_WIDTH = DATA_WIDTH / 8
) ();

  logic [ADDR_WIDTH-1:0]  PADDR;
  logic [2:0]             PPROT;
  logic                   PSELx;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [DATA_WIDTH-1:0]  PWDATA;
  logic [PSTRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]  PRDATA;
  logic                   PREADY;
  logic                   PSLVERR;

  modport master (
    output PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_addr_decoder.sv
// Combinational channel select plus legality checks for an incoming APB setup phase.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH   = APB_ADDR_WIDTH,
  parameter int PSTRB_WIDTH  = APB_PSTRB_WIDTH,
  parameter int NUM_CH       = 4,
  parameter int CH_ADDR_BITS = 12,
  parameter logic [NUM_CH-1:0] SECURE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0]        paddr,
  input  logic                         pprot_ns,
  input  logic                         pwrite,
  input  logic [PSTRB_WIDTH-1:0]       pstrb,
  output logic [idx_bits(NUM_CH)-1:0]  ch_idx,
  output apb_err_cause_e               err_cause
);

  localparam int CH_W       = idx_bits(NUM_CH);
  localparam int FIELD_BITS = $clog2(NUM_CH);

  logic upper_nonzero;
  logic ch_out_of_range;

  assign ch_idx          = CH_W'(paddr >> CH_ADDR_BITS);
  assign upper_nonzero   = (paddr >> (CH_ADDR_BITS + FIELD_BITS)) != '0;
  assign ch_out_of_range = 32'(ch_idx) >= NUM_CH;

  // Address problems take priority so the secure mask is never indexed out of range.
  always_comb begin
    err_cause = ERR_NONE;
    if (upper_nonzero || ch_out_of_range) begin
      err_cause = ERR_DECODE;
    end else if (pprot_ns && SECURE_MASK[ch_idx]) begin
      err_cause = ERR_SECURE;
    end else if (!pwrite && (pstrb != '0)) begin
      err_cause = ERR_STRB;
    end
  end

endmodule

// File: rtl/apb_multi_slave_bridge.sv
// APB4 completer fanning out to NUM_CH ready/readData peripherals, with decode,
// secure, strobe and wait-state timeout checks reported through PSLVERR.
module apb_multi_slave_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH   = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = APB_DATA_WIDTH,
  parameter int PSTRB_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_CH       = 4,
  parameter int CH_ADDR_BITS = 12,
  parameter int TIMEOUT      = 16,
  parameter logic [NUM_CH-1:0] SECURE_MASK = '0
) (
  input  logic                         clk,
  input  logic                         PRESETn,
  apb_multi_slave_bridge_if.slave      apb,
  output logic [NUM_CH-1:0]            ch_enable,
  output logic                         ch_write_read,
  output logic [CH_ADDR_BITS-1:0]      ch_address,
  output logic [DATA_WIDTH-1:0]        ch_writeData,
  output logic [PSTRB_WIDTH-1:0]       ch_strb,
  input  logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_readData
);

  localparam int  CH_W       = idx_bits(NUM_CH);
  localparam int  CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit  TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_bridge_state_e     state_q, state_d;
  apb_err_cause_e        dec_cause;
  apb_err_cause_e        err_cause_q;
  logic [CH_W-1:0]       dec_ch;
  logic [CH_W-1:0]       ch_idx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  setup;
  logic                  sel_ready;
  logic                  timeout_hit;
  logic                  pready_int;
  logic                  pslverr_int;
  logic                  unused_pprot;

  apb_addr_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .PSTRB_WIDTH  (PSTRB_WIDTH),
    .NUM_CH       (NUM_CH),
    .CH_ADDR_BITS (CH_ADDR_BITS),
    .SECURE_MASK  (SECURE_MASK)
  ) u_decoder (
    .paddr     (apb.PADDR),
    .pprot_ns  (apb.PPROT[1]),
    .pwrite    (apb.PWRITE),
    .pstrb     (apb.PSTRB),
    .ch_idx    (dec_ch),
    .err_cause (dec_cause)
  );

  assign unused_pprot = ^{apb.PPROT[2], apb.PPROT[0]};

  assign setup       = apb.PSELx && !apb.PENABLE;
  assign sel_ready   = ch_ready[ch_idx_q];
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A dropped PSELx mid-wait abandons the transfer silently; ready wins over timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = (dec_cause != ERR_NONE) ? ERR : BUSY;
        end
      end
      BUSY: begin
        if (!apb.PSELx) begin
          state_d = IDLE;
        end else if (sel_ready || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      ch_idx_q      <= '0;
      ch_write_read <= 1'b0;
      ch_address    <= '0;
      ch_writeData  <= '0;
      ch_strb       <= '0;
      prdata_q      <= '0;
      err_cause_q   <= ERR_NONE;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (setup) begin
            ch_idx_q      <= dec_ch;
            ch_write_read <= apb.PWRITE;
            ch_address    <= apb.PADDR[CH_ADDR_BITS-1:0];
            ch_writeData  <= apb.PWDATA;
            ch_strb       <= apb.PSTRB;
            err_cause_q   <= dec_cause;
            cnt_q         <= '0;
            if (dec_cause != ERR_NONE) begin
              prdata_q <= '0;
            end
          end
        end
        BUSY: begin
          if (!apb.PSELx) begin
            cnt_q <= '0;
          end else if (sel_ready) begin
            prdata_q <= ch_write_read ? '0 : ch_readData[ch_idx_q*DATA_WIDTH +: DATA_WIDTH];
            cnt_q    <= '0;
          end else if (timeout_hit) begin
            prdata_q    <= '0;
            err_cause_q <= ERR_TIMEOUT;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response flags decode straight from registered state, keeping PREADY off any input path.
  always_comb begin
    ch_enable   = '0;
    pready_int  = 1'b0;
    pslverr_int = 1'b0;
    case (state_q)
      BUSY: ch_enable[ch_idx_q] = 1'b1;
      DONE: begin
        pready_int  = 1'b1;
        pslverr_int = (err_cause_q != ERR_NONE);
      end
      ERR: begin
        pready_int  = 1'b1;
        pslverr_int = 1'b1;
      end
      default: ;
    endcase
  end

  assign apb.PREADY  = pready_int;
  assign apb.PSLVERR = pslverr_int;
  assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// Directed bench for apb_multi_slave_bridge: 4 channels, 4 KiB windows, channel 2 secure.
module tb_apb_multi_slave_bridge;

  logic          clk;
  logic          PRESETn;
  logic [3:0]    ch_enable;
  logic          ch_write_read;
  logic [11:0]   ch_address;
  logic [31:0]   ch_writeData;
  logic [3:0]    ch_strb;
  logic [3:0]    ch_ready;
  logic [127:0]  ch_readData;

  int checks;
  int errors;

  int          lat;
  int          en_cycles;
  logic [31:0] rdata;
  logic        slverr;
  logic [3:0]  en_seen;
  logic [11:0] obs_addr;
  logic [31:0] obs_wdata;
  logic        obs_wr;
  logic [3:0]  obs_strb;

  apb_multi_slave_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PSTRB_WIDTH(4)) apb ();

  apb_multi_slave_bridge #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .PSTRB_WIDTH  (4),
    .NUM_CH       (4),
    .CH_ADDR_BITS (12),
    .TIMEOUT      (16),
    .SECURE_MASK  (4'b0100)
  ) dut (
    .clk           (clk),
    .PRESETn       (PRESETn),
    .apb           (apb),
    .ch_enable     (ch_enable),
    .ch_write_read (ch_write_read),
    .ch_address    (ch_address),
    .ch_writeData  (ch_writeData),
    .ch_strb       (ch_strb),
    .ch_ready      (ch_ready),
    .ch_readData   (ch_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full APB transfer; ready_after<0 means the selected channel never answers.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [2:0] prot,
                               input int ready_ch, input int ready_after, input logic [3:0] noise);
    bit done;
    apb.PSELx   = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PADDR   = addr;
    apb.PWRITE  = wr;
    apb.PWDATA  = wdata;
    apb.PSTRB   = strb;
    apb.PPROT   = prot;
    ch_ready    = noise;
    tick();
    apb.PENABLE = 1'b1;
    obs_addr  = ch_address;
    obs_wdata = ch_writeData;
    obs_wr    = ch_write_read;
    obs_strb  = ch_strb;
    lat       = 1;
    en_seen   = 4'b0;
    en_cycles = 0;
    done      = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      en_seen = en_seen | ch_enable;
      if (apb.PREADY) begin
        done = 1'b1;
      end else begin
        if (ch_enable != 4'b0) en_cycles++;
        ch_ready = noise;
        if (ready_after >= 0 && c >= ready_after) ch_ready[ready_ch] = 1'b1;
        tick();
        lat++;
      end
    end
    if (!done) lat = -1;
    rdata  = apb.PRDATA;
    slverr = apb.PSLVERR;
    apb.PSELx   = 1'b0;
    apb.PENABLE = 1'b0;
    ch_ready    = 4'b0;
    tick();
    checkOutput("ready_drop", {31'b0, apb.PREADY}, 32'h0);
    checkOutput("slverr_drop", {31'b0, apb.PSLVERR}, 32'h0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    PRESETn     = 1'b0;
    apb.PADDR   = '0;
    apb.PPROT   = '0;
    apb.PSELx   = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PWDATA  = '0;
    apb.PSTRB   = '0;
    ch_ready    = '0;
    ch_readData = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pready", {31'b0, apb.PREADY}, 32'h0);
    checkOutput("rst_pslverr", {31'b0, apb.PSLVERR}, 32'h0);
    checkOutput("rst_prdata", apb.PRDATA, 32'h0);
    checkOutput("rst_enable", {28'b0, ch_enable}, 32'h0);
    PRESETn = 1'b1;
    tick();

    $display("[TB] write ch1");
    applyStimulus(32'h0000_1010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, 1, 0, 4'b0000);
    checkOutput("wr_lat", 32'(lat), 32'd2);
    checkOutput("wr_enable", {28'b0, en_seen}, 32'h2);
    checkOutput("wr_en_cycles", 32'(en_cycles), 32'd1);
    checkOutput("wr_address", {20'b0, obs_addr}, 32'h010);
    checkOutput("wr_wdata", obs_wdata, 32'hDEAD_BEEF);
    checkOutput("wr_dir", {31'b0, obs_wr}, 32'h1);
    checkOutput("wr_strb", {28'b0, obs_strb}, 32'hF);
    checkOutput("wr_slverr", {31'b0, slverr}, 32'h0);
    checkOutput("wr_prdata", rdata, 32'h0);

    $display("[TB] read ch3 with late ready and noise on other channels");
    ch_readData[3*32 +: 32] = 32'h1234_5678;
    ch_readData[0*32 +: 32] = 32'hBAD0_0000;
    applyStimulus(32'h0000_3004, 1'b0, 32'h0, 4'h0, 3'b000, 3, 2, 4'b0111);
    checkOutput("rd3_lat", 32'(lat), 32'd4);
    checkOutput("rd3_enable", {28'b0, en_seen}, 32'h8);
    checkOutput("rd3_address", {20'b0, obs_addr}, 32'h004);
    checkOutput("rd3_dir", {31'b0, obs_wr}, 32'h0);
    checkOutput("rd3_prdata", rdata, 32'h1234_5678);
    checkOutput("rd3_slverr", {31'b0, slverr}, 32'h0);

    $display("[TB] decode error above channel field");
    applyStimulus(32'h0001_4000, 1'b0, 32'h0, 4'h0, 3'b000, 0, 0, 4'b0000);
    checkOutput("dec_lat", 32'(lat), 32'd1);
    checkOutput("dec_slverr", {31'b0, slverr}, 32'h1);
    checkOutput("dec_prdata", rdata, 32'h0);
    checkOutput("dec_enable", {28'b0, en_seen}, 32'h0);

    $display("[TB] non-secure write to secure channel 2");
    applyStimulus(32'h0000_2000, 1'b1, 32'h0BAD_F00D, 4'h3, 3'b010, 2, 0, 4'b0000);
    checkOutput("sec_lat", 32'(lat), 32'd1);
    checkOutput("sec_slverr", {31'b0, slverr}, 32'h1);
    checkOutput("sec_enable", {28'b0, en_seen}, 32'h0);

    $display("[TB] secure write to channel 2");
    applyStimulus(32'h0000_2000, 1'b1, 32'h0BAD_F00D, 4'h3, 3'b000, 2, 0, 4'b0000);
    checkOutput("secok_lat", 32'(lat), 32'd2);
    checkOutput("secok_slverr", {31'b0, slverr}, 32'h0);
    checkOutput("secok_enable", {28'b0, en_seen}, 32'h4);
    checkOutput("secok_strb", {28'b0, obs_strb}, 32'h3);

    $display("[TB] read ch1 with two wait states");
    ch_readData[1*32 +: 32] = 32'hCAFE_0001;
    applyStimulus(32'h0000_1008, 1'b0, 32'h0, 4'h0, 3'b000, 1, 1, 4'b0000);
    checkOutput("rd1_lat", 32'(lat), 32'd3);
    checkOutput("rd1_prdata", rdata, 32'hCAFE_0001);

    $display("[TB] timeout on channel 0");
    ch_readData[0*32 +: 32] = 32'h5555_AAAA;
    applyStimulus(32'h0000_0000, 1'b0, 32'h0, 4'h0, 3'b000, 0, -1, 4'b0000);
    checkOutput("to_lat", 32'(lat), 32'd17);
    checkOutput("to_en_cycles", 32'(en_cycles), 32'd16);
    checkOutput("to_enable", {28'b0, en_seen}, 32'h1);
    checkOutput("to_slverr", {31'b0, slverr}, 32'h1);
    checkOutput("to_prdata", rdata, 32'h0);

    $display("[TB] read with nonzero strobe");
    applyStimulus(32'h0000_1000, 1'b0, 32'h0, 4'h1, 3'b000, 1, 0, 4'b0000);
    checkOutput("strb_lat", 32'(lat), 32'd1);
    checkOutput("strb_slverr", {31'b0, slverr}, 32'h1);
    checkOutput("strb_enable", {28'b0, en_seen}, 32'h0);

    $display("[TB] write with zero strobe is forwarded");
    applyStimulus(32'h0000_3ffc, 1'b1, 32'h0000_0042, 4'h0, 3'b000, 3, 0, 4'b0000);
    checkOutput("zstrb_lat", 32'(lat), 32'd2);
    checkOutput("zstrb_slverr", {31'b0, slverr}, 32'h0);
    checkOutput("zstrb_address", {20'b0, obs_addr}, 32'hFFC);

    $display("[TB] master drops PSELx mid-wait");
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 32'h0000_1000;
    apb.PWRITE = 1'b0; apb.PSTRB = 4'h0;
    tick();
    checkOutput("abort_busy_enable", {28'b0, ch_enable}, 32'h2);
    apb.PSELx = 1'b0;
    tick();
    checkOutput("abort_enable", {28'b0, ch_enable}, 32'h0);
    checkOutput("abort_pready", {31'b0, apb.PREADY}, 32'h0);
    tick();
    checkOutput("abort_pready_later", {31'b0, apb.PREADY}, 32'h0);

    $display("[TB] async reset during wait");
    ch_readData[1*32 +: 32] = 32'h1357_2468;
    applyStimulus(32'h0000_1004, 1'b0, 32'h0, 4'h0, 3'b000, 1, 0, 4'b0000);
    checkOutput("pre_rst_prdata", rdata, 32'h1357_2468);
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 32'h0000_1abc;
    apb.PWRITE = 1'b1; apb.PWDATA = 32'hFFFF_0000; apb.PSTRB = 4'hC;
    tick();
    apb.PENABLE = 1'b1;
    checkOutput("rst_mid_busy", {28'b0, ch_enable}, 32'h2);
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("rst_mid_enable", {28'b0, ch_enable}, 32'h0);
    checkOutput("rst_mid_prdata", apb.PRDATA, 32'h0);
    checkOutput("rst_mid_address", {20'b0, ch_address}, 32'h0);
    checkOutput("rst_mid_wdata", ch_writeData, 32'h0);
    checkOutput("rst_mid_pready", {31'b0, apb.PREADY}, 32'h0);
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
    tick();
    checkOutput("rst_hold_pready", {31'b0, apb.PREADY}, 32'h0);
    PRESETn = 1'b1;
    tick();

    ch_readData[1*32 +: 32] = 32'hA5A5_0F0F;
    applyStimulus(32'h0000_1020, 1'b0, 32'h0, 4'h0, 3'b000, 1, 0, 4'b0000);
    checkOutput("post_rst_lat", 32'(lat), 32'd2);
    checkOutput("post_rst_prdata", rdata, 32'hA5A5_0F0F);
    checkOutput("post_rst_slverr", {31'b0, slverr}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_multi_slave_bridge.md
Name: apb_multi_slave_bridge

Overview:
- Next-generation APB4 slave bridge: one APB completer port fanned out to NUM_CH peripheral channels.
- Each channel is a ready/readData handshake peripheral, generalised from the single-peripheral interface.
- Adds address decode, a per-channel secure-access check, PSTRB legality check, a wait-state timeout counter and PSLVERR generation.
- Sits between the APB interconnect and the peripheral register blocks.

Parameters:
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, data width
- PSTRB_WIDTH, DATA_WIDTH/8, strobe width
- NUM_CH, 4, number of peripheral channels (1..16)
- CH_ADDR_BITS, 12, per-channel window = 2^CH_ADDR_BITS bytes
- TIMEOUT, 16, max cycles waiting for ch_ready; 0 = never time out
- SECURE_MASK, '0, NUM_CH bits; bit i=1 means channel i rejects non-secure access (PPROT[1]=1)

Ports:
- clk  in  1  clock
- PRESETn  in  1  async active-low reset
- PADDR  in  ADDR_WIDTH  APB address
- PPROT  in  3  protection
- PSELx  in  1  select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  PSTRB_WIDTH  write strobes
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- ch_enable  out  NUM_CH  one-hot request to channel
- ch_write_read  out  1  1=write
- ch_address  out  CH_ADDR_BITS  offset within window
- ch_writeData  out  DATA_WIDTH  write data
- ch_strb  out  PSTRB_WIDTH  strobes
- ch_ready  in  NUM_CH  per-channel done
- ch_readData  in  NUM_CH*DATA_WIDTH  flattened read data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Interface: one clock, clk; reset PRESETn is asynchronous, active-low.
- Reset: all outputs 0, FSM IDLE, timeout counter 0. Applies asynchronously, including mid-transfer; any pending transfer is dropped with no response.
- Decode: ch = PADDR[CH_ADDR_BITS +: clog2(NUM_CH)]. Decode error if any of the following:
  - PADDR bits above the decode field are nonzero
  - ch >= NUM_CH
  - SECURE_MASK[ch]=1 and PPROT[1]=1
  - PWRITE=0 and PSTRB != 0
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - On PSELx=1 and PENABLE=0 (setup phase), latch ch, PWRITE, PADDR[CH_ADDR_BITS-1:0], PWDATA and PSTRB into the ch_* registers.
  - Next state is ERR on decode error, else BUSY.
  - PREADY=0.
- BUSY:
  - ch_enable[ch]=1; other bits 0. ch_* outputs stay stable.
  - Counter increments each cycle.
  - ch_ready[ch]=1: capture ch_readData slice into PRDATA (reads only; writes load PRDATA=0), clear counter, go to DONE.
  - ch_ready of non-selected channels is ignored.
  - Counter = TIMEOUT-1 with no ready (TIMEOUT != 0): drop ch_enable, set error flag, PRDATA=0, go to DONE.
- DONE:
  - PREADY=1, PSLVERR=error flag, ch_enable=0.
  - Next cycle: IDLE, PREADY=0, PSLVERR=0, PRDATA held until the next completion.
- ERR:
  - PREADY=1, PSLVERR=1, PRDATA=0; ch_enable is never asserted.
  - Next state IDLE.
- Latency, setup at cycle T:
  - Normal: ch_enable at T+1. With ch_ready at T+1, PREADY at T+2 (one wait state). Each extra ready cycle adds one wait state.
  - Decode error: PREADY=1, PSLVERR=1 at T+1 (zero wait states).
- PSELx=0 while in BUSY (master protocol violation): return to IDLE next cycle, ch_enable=0, no PREADY pulse, counter cleared.
- Back-to-back: a setup phase in the cycle after DONE/ERR is accepted normally.
- A write with PSTRB=0 is legal and is forwarded.
- PREADY and PSLVERR are registered (FSM state decode). No combinational path from APB inputs to PREADY.

Decomposition:
- Shared package apb_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH and PSTRB_WIDTH defaults
  - state enum apb_bridge_state_e {IDLE, BUSY, DONE, ERR}
  - error-cause enum {ERR_NONE, ERR_DECODE, ERR_SECURE, ERR_STRB, ERR_TIMEOUT}, kept internally for debug/coverage
- Sub-module apb_addr_decoder: combinational channel index plus decode/secure/strobe checks.

Test Plan (NUM_CH=4, CH_ADDR_BITS=12, TIMEOUT=16, SECURE_MASK=4'b0100):
- Write PADDR=0x1010, PWDATA=0xDEADBEEF, PSTRB=4'hF; ch_ready[1] one cycle after enable -> ch_enable=4'b0010, ch_address=0x010, ch_writeData=0xDEADBEEF, PREADY at T+2, PSLVERR=0.
- Read PADDR=0x3004, ch_readData[3]=0x12345678, ch_ready[3] three cycles late -> PREADY at T+4, PRDATA=0x12345678, PSLVERR=0.
- Read PADDR=0x0001_4000 -> ERR: PREADY=1, PSLVERR=1 at T+1, PRDATA=0, ch_enable stays 0.
- Write PADDR=0x2000 with PPROT=3'b010 -> PSLVERR=1, ch_enable never set. Same transfer with PPROT=3'b000 -> normal completion.
- Read PADDR=0x0000, ch_ready held 0 -> ch_enable high 16 cycles, then PREADY=1, PSLVERR=1, PRDATA=0. Read with PSTRB=4'h1 -> PSLVERR=1 at T+1.
- PRESETn low during BUSY -> all outputs 0 immediately. After release, the next transfer completes normally.
